// File: rtl/conv1_mxmult_arbiter.sv
// Round-robin scheduler sharing the conv1 layer1 25-lane multiplier array between
// the A-matrix path (port 0) and the feature-update path (port 1), with a result watchdog.
module conv1_mxmult_arbiter #(
  parameter int DATA_W  = 400,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_v0,
  input  logic              req_v1,
  output logic              req_rdy0,
  output logic              req_rdy1,
  input  logic [DATA_W-1:0] fea0,
  input  logic [DATA_W-1:0] fea1,
  input  logic [DATA_W-1:0] amx0,
  input  logic [DATA_W-1:0] amx1,
  output logic [DATA_W-1:0] res,
  output logic              res_v0,
  output logic              res_v1,
  output logic              err,
  output logic              err_id,
  output logic              mx_start,
  output logic              mx_data_v,
  output logic [DATA_W-1:0] mx_in_fea,
  output logic [DATA_W-1:0] mx_a_mx,
  input  logic [DATA_W-1:0] mx_res,
  input  logic              mx_res_v
);

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] WDOG_LAST = 4'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic               owner_q, owner_d;
  logic [3:0]         wdog_q, wdog_d;
  logic [DATA_W-1:0]  fea_op_q, fea_op_d;
  logic [DATA_W-1:0]  amx_op_q, amx_op_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic [1:0]         res_v_q, res_v_d;
  logic               err_q, err_d;
  logic               err_id_q, err_id_d;
  logic               mx_start_q, mx_start_d;
  logic               mx_data_v_q, mx_data_v_d;
  logic               grant;
  logic               idle;

  // With both ports requesting the pointer decides; otherwise the lone requester wins.
  assign grant    = (req_v0 && req_v1) ? rr_ptr_q : req_v1;
  assign idle     = (state_q == IDLE);
  assign req_rdy0 = idle && req_v0 && !grant;
  assign req_rdy1 = idle && req_v1 && grant;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    wdog_d      = wdog_q;
    fea_op_d    = fea_op_q;
    amx_op_d    = amx_op_q;
    res_d       = res_q;
    res_v_d     = 2'b00;
    err_d       = 1'b0;
    err_id_d    = err_id_q;
    mx_start_d  = 1'b0;
    mx_data_v_d = 1'b0;
    case (state_q)
      INIT: begin
        if (!mx_start_q) mx_start_d = 1'b1;
        else             state_d    = IDLE;
      end
      IDLE: begin
        if (req_v0 || req_v1) begin
          fea_op_d    = grant ? fea1 : fea0;
          amx_op_d    = grant ? amx1 : amx0;
          owner_d     = grant;
          rr_ptr_d    = ~grant;
          mx_data_v_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = 4'd0;
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving on the timeout cycle takes precedence over the abort.
        if (mx_res_v) begin
          res_d   = mx_res;
          res_v_d = owner_q ? 2'b10 : 2'b01;
          state_d = DONE;
        end else if (wdog_q == WDOG_LAST) begin
          err_d    = 1'b1;
          err_id_d = owner_q;
          state_d  = IDLE;
        end else begin
          wdog_d = wdog_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      wdog_q      <= 4'd0;
      fea_op_q    <= '0;
      amx_op_q    <= '0;
      res_q       <= '0;
      res_v_q     <= 2'b00;
      err_q       <= 1'b0;
      err_id_q    <= 1'b0;
      mx_start_q  <= 1'b0;
      mx_data_v_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      wdog_q      <= wdog_d;
      fea_op_q    <= fea_op_d;
      amx_op_q    <= amx_op_d;
      res_q       <= res_d;
      res_v_q     <= res_v_d;
      err_q       <= err_d;
      err_id_q    <= err_id_d;
      mx_start_q  <= mx_start_d;
      mx_data_v_q <= mx_data_v_d;
    end
  end

  assign res       = res_q;
  assign res_v0    = res_v_q[0];
  assign res_v1    = res_v_q[1];
  assign err       = err_q;
  assign err_id    = err_id_q;
  assign mx_start  = mx_start_q;
  assign mx_data_v = mx_data_v_q;
  assign mx_in_fea = fea_op_q;
  assign mx_a_mx   = amx_op_q;

endmodule

// File: tb/tb_conv1_mxmult_arbiter.sv
// Directed bench for conv1_mxmult_arbiter: a delay-3 array model plus a manual result
// override for watchdog races, with hand-computed expectations checked by immediate assertions.
module tb_conv1_mxmult_arbiter;
  localparam int DATA_W = 400;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_v0, req_v1, req_rdy0, req_rdy1;
  logic [DATA_W-1:0] fea0, fea1, amx0, amx1;
  logic [DATA_W-1:0] res, mx_in_fea, mx_a_mx, mx_res;
  logic              res_v0, res_v1, err, err_id, mx_start, mx_data_v, mx_res_v;

  bit                model_en = 1'b0;
  int                model_cnt = 0;
  logic              model_res_v = 1'b0;
  logic [DATA_W-1:0] model_res = '0;
  logic              man_res_v = 1'b0;
  logic [DATA_W-1:0] man_res = '0;

  int total, bad, cyc, t0;
  int pulse [3];
  bit found, ok;

  always #5 clk = ~clk;

  assign mx_res_v = model_res_v | man_res_v;
  assign mx_res   = man_res_v ? man_res : model_res;

  conv1_mxmult_arbiter #(.DATA_W(DATA_W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_v0(req_v0), .req_v1(req_v1), .req_rdy0(req_rdy0), .req_rdy1(req_rdy1),
    .fea0(fea0), .fea1(fea1), .amx0(amx0), .amx1(amx1),
    .res(res), .res_v0(res_v0), .res_v1(res_v1), .err(err), .err_id(err_id),
    .mx_start(mx_start), .mx_data_v(mx_data_v), .mx_in_fea(mx_in_fea), .mx_a_mx(mx_a_mx),
    .mx_res(mx_res), .mx_res_v(mx_res_v)
  );

  // Array model: result valid 3 cycles after the operand-valid cycle, lane = (fea*amx)>>16.
  always @(negedge clk) begin : array_model
    logic [31:0] prod;
    model_res_v = 1'b0;
    if (model_cnt > 0) begin
      model_cnt = model_cnt - 1;
      if (model_cnt == 0) model_res_v = 1'b1;
    end
    if (model_en && mx_data_v === 1'b1) begin
      model_cnt = 3;
      for (int i = 0; i < 25; i++) begin
        prod = mx_in_fea[i*16 +: 16] * mx_a_mx[i*16 +: 16];
        model_res[i*16 +: 16] = prod[31:16];
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic step;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    total = total + 1;
    assert (obs === exp)
    else begin
      bad = bad + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [15:0] f0, input logic [15:0] a0,
                               input logic [15:0] f1, input logic [15:0] a1);
    req_v0 = v0;
    req_v1 = v1;
    fea0   = DATA_W'(f0);
    amx0   = DATA_W'(a0);
    fea1   = DATA_W'(f1);
    amx1   = DATA_W'(a1);
  endtask

  task automatic waitResult(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!seen) begin
        step;
        seen = (res_v0 === 1'b1) || (res_v1 === 1'b1) || (err === 1'b1);
      end
    end
  endtask

  // Returns just after the edge on which the given port handshook.
  task automatic waitReady(input bit port, output bit hs);
    hs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!hs) begin
        #1;
        hs = port ? (req_rdy1 === 1'b1) : (req_rdy0 === 1'b1);
        step;
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0200, 16'h0300, 16'h0, 16'h0);
    model_en = 1'b1;
    step; step;

    checkOutput("rst_rdy0", req_rdy0, 0);
    checkOutput("rst_res", res, 0);
    checkOutput("rst_resv", {res_v1, res_v0}, 0);
    checkOutput("rst_err", {err, err_id}, 0);
    checkOutput("rst_mxctl", {mx_start, mx_data_v}, 0);
    checkOutput("rst_mxop", mx_in_fea | mx_a_mx, 0);

    rst = 1'b1;
    step;
    checkOutput("init_start", mx_start, 1);
    checkOutput("init_rdy0", req_rdy0, 0);
    step;
    checkOutput("init_start_drop", mx_start, 0);
    checkOutput("idle_rdy0", req_rdy0, 1);
    checkOutput("idle_rdy1", req_rdy1, 0);
    step;
    checkOutput("issue_dv", mx_data_v, 1);
    checkOutput("issue_fea", mx_in_fea, 16'h0200);
    checkOutput("issue_amx", mx_a_mx, 16'h0300);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    t0 = cyc;
    waitResult(found);
    checkOutput("p0_seen", found, 1);
    checkOutput("p0_latency", cyc - t0, 4);
    checkOutput("p0_strobe", {err, res_v1, res_v0}, 3'b001);
    checkOutput("p0_res", res, 16'h0006);
    step;
    checkOutput("p0_pulse_once", {res_v1, res_v0}, 0);
    checkOutput("p0_res_hold", res, 16'h0006);

    $display("[TB] single requester on port 1");
    applyStimulus(1'b0, 1'b1, 16'h0, 16'h0, 16'h0100, 16'h0700);
    for (int i = 0; i < 3; i++) begin
      waitResult(found);
      pulse[i] = cyc;
      checkOutput("p1_seen", found, 1);
      checkOutput("p1_strobe", {err, res_v1, res_v0}, 3'b010);
      checkOutput("p1_res", res, 16'h0007);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    checkOutput("p1_spacing_a", pulse[1] - pulse[0], 6);
    checkOutput("p1_spacing_b", pulse[2] - pulse[1], 6);

    $display("[TB] contention");
    applyStimulus(1'b1, 1'b1, 16'h0400, 16'h0500, 16'h0100, 16'h0700);
    step;
    checkOutput("cont_rdy", {req_rdy1, req_rdy0}, 2'b01);
    for (int i = 0; i < 4; i++) begin
      waitResult(found);
      checkOutput("cont_seen", found, 1);
      checkOutput("cont_owner", {err, res_v1, res_v0}, (i % 2 == 1) ? 3'b010 : 3'b001);
      checkOutput("cont_res", res, (i % 2 == 1) ? 16'h0007 : 16'h0014);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

    $display("[TB] watchdog abort on port 1");
    model_en = 1'b0;
    applyStimulus(1'b0, 1'b1, 16'h0, 16'h0, 16'h0111, 16'h0222);
    waitReady(1'b1, ok);
    checkOutput("wd_hs", ok, 1);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    t0 = cyc;
    waitResult(found);
    checkOutput("wd_seen", found, 1);
    checkOutput("wd_latency", cyc - t0, 16);
    checkOutput("wd_strobe", {err, res_v1, res_v0}, 3'b100);
    checkOutput("wd_err_id", err_id, 1);
    step;
    checkOutput("wd_err_pulse", err, 0);
    checkOutput("wd_err_id_hold", err_id, 1);

    man_res   = DATA_W'(16'h00EE);
    man_res_v = 1'b1;
    step;
    man_res_v = 1'b0;
    checkOutput("idle_resv_ignored", {res_v1, res_v0}, 0);
    checkOutput("idle_res_unchanged", res, 16'h0007);

    $display("[TB] result on the timeout cycle");
    applyStimulus(1'b1, 1'b0, 16'h0333, 16'h0444, 16'h0, 16'h0);
    waitReady(1'b0, ok);
    checkOutput("race_hs", ok, 1);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (15) step;
    man_res   = DATA_W'(16'h00AB);
    man_res_v = 1'b1;
    step;
    man_res_v = 1'b0;
    checkOutput("race_strobe", {err, res_v1, res_v0}, 3'b001);
    checkOutput("race_res", res, 16'h00AB);
    step;
    checkOutput("race_no_err", {err, res_v0}, 0);
    checkOutput("race_err_id_hold", err_id, 1);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 1'b0, 16'h0555, 16'h0666, 16'h0, 16'h0);
    waitReady(1'b0, ok);
    checkOutput("mid_hs", ok, 1);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    step; step;
    rst = 1'b0;
    #1;
    checkOutput("mid_async_res", res, 0);
    checkOutput("mid_async_op", mx_in_fea | mx_a_mx, 0);
    checkOutput("mid_async_err_id", err_id, 0);
    step;
    rst       = 1'b1;
    man_res   = DATA_W'(16'h0099);
    man_res_v = 1'b1;
    step;
    man_res_v = 1'b0;
    checkOutput("mid_init_start", mx_start, 1);
    checkOutput("mid_late_resv", {res_v1, res_v0}, 0);
    checkOutput("mid_late_res", res, 0);
    step;
    checkOutput("mid_start_drop", mx_start, 0);

    model_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0200, 16'h0300, 16'h0, 16'h0);
    waitReady(1'b0, ok);
    checkOutput("post_hs", ok, 1);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    t0 = cyc;
    waitResult(found);
    checkOutput("post_seen", found, 1);
    checkOutput("post_latency", cyc - t0, 4);
    checkOutput("post_strobe", {err, res_v1, res_v0}, 3'b001);
    checkOutput("post_res", res, 16'h0006);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv1_mxmult_arbiter.md
# conv1_mxmult_arbiter

Scheduler that shares the single conv1 layer1 25-lane dense multiplier array (25 × 16x16 DSP, 400-bit operand/result vectors) between two requesters: the A-matrix path (port 0) and the feature-update path (port 1). Accepts one operation at a time via valid/ready and arbitrates round-robin. Drives the array's start/data_v/operand inputs, waits for its result-valid, and routes the 400-bit result back to the owning requester. A watchdog aborts operations whose result never returns.

## Interface
- DATA_W, 400, operand and result vector width (25 lanes × 16 bit)
- TIMEOUT, 15, max cycles in WAIT before abort (4-bit counter; legal 4..15)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- req_v0 / req_v1  input  1  requester 0/1 operation valid
- req_rdy0 / req_rdy1  output  1  requester 0/1 accept; handshake = req_v & req_rdy
- fea0 / fea1  input  DATA_W  requester 0/1 feature vector
- amx0 / amx1  input  DATA_W  requester 0/1 A-matrix vector
- res  output  DATA_W  result bus shared by both requesters
- res_v0 / res_v1  output  1  one-cycle result strobe for requester 0/1
- err  output  1  one-cycle watchdog-abort strobe
- err_id  output  1  requester owning the aborted op; held until next abort
- mx_start  output  1  array start pulse
- mx_data_v  output  1  array operand valid
- mx_in_fea  output  DATA_W  array feature operand
- mx_a_mx  output  DATA_W  array A-matrix operand
- mx_res  input  DATA_W  array result vector
- mx_res_v  input  1  array result valid

## Operation
- States: INIT, IDLE, ISSUE, WAIT, DONE. Reset state is INIT.
- INIT (1 cycle after reset release): mx_start=1, then go to IDLE.
- IDLE: req_rdy0/1 are high only here, and only for the port the arbiter would grant this cycle. The other port's ready stays 0.
  - Grant rule: if only one port's req_v is set, grant that port. If both are set, grant the port = rr_ptr.
  - On handshake: latch fea/amx into operand registers, latch owner, set rr_ptr = ~owner, go to ISSUE.
- ISSUE (1 cycle): mx_data_v=1, and mx_in_fea/mx_a_mx carry the latched operands. Go to WAIT and clear wdog.
- WAIT: operands stay held on mx_in_fea/mx_a_mx and mx_data_v=0. wdog increments each cycle.
  - mx_res_v=1: capture mx_res into res, go to DONE.
  - wdog==TIMEOUT-1 with no mx_res_v: err=1 next cycle, err_id=owner, go to IDLE with no res_v.
  - mx_res_v on the same cycle as the timeout: the result wins and no err is raised.
- DONE (1 cycle): res_v[owner]=1, go to IDLE.
- mx_res_v arriving in INIT/IDLE/ISSUE/DONE is ignored and res is unchanged.
- rr_ptr reset value is 0. rr_ptr updates only on handshake, not on abort.
- res holds its value until the next capture.

## Timing
- Reset values: req_rdy0/1=0, res=0, res_v0/1=0, err=0, err_id=0, mx_start=0, mx_data_v=0, mx_in_fea=0, mx_a_mx=0.
- Reset is asynchronous: asserting rst mid-operation forces all registers to reset values immediately and the in-flight op is dropped. After release, INIT repeats.
- Handshake at edge T, then mx_data_v high in cycle T+1.
- If mx_res_v is sampled at edge T+1+k (k≥1), res_v rises at T+2+k. res is valid in that same cycle.
- Earliest next handshake is the cycle after DONE. With the nominal array result delay of 3 cycles, one op completes per 6 cycles.
- All outputs are registered with no combinational input-to-output paths. The exception is req_rdy, which is decoded from state, rr_ptr and req_v.

## Test plan
- Reset and INIT: release rst → mx_start high for exactly 1 cycle. All other outputs stay 0, and req_rdy0=1 in the next cycle when req_v0=1.
- Single op, port 0: fea0 lane0=0x0200, amx0 lane0=0x0300, array model returns mx_res_v 3 cycles after mx_data_v with res lane0=0x0006 → res_v0 pulses once, res_v1=0, res[15:0]=0x0006.
- Contention: req_v0=req_v1=1 held for 4 ops → grants go 0,1,0,1. Each result strobes only the owner's res_v.
- Single requester: req_v1 only, 3 back-to-back ops → all granted to port 1 despite rr_ptr, with spacing of 6 cycles each.
- Watchdog: array model never asserts mx_res_v → err pulses 15 cycles after ISSUE with err_id=owner. No res_v, and IDLE accepts the next request. A mx_res_v on the timeout cycle → res_v, no err.
- Mid-op reset: assert rst during WAIT, then send a late mx_res_v after release → no res_v, INIT mx_start pulse, normal op completes afterwards.
